timer_digit_loader: RTL



---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_digit_dec.sv | 32 +++
 rtl/timer_digit_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// +--------------------------------------------------------------------------+
// | timer_pkg: shared states, BCD constants and digit type for the timer.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_dec.sv
// +--------------------------------------------------------------------------+
// | bcd_digit_dec: combinational single-digit decrementer with borrow chain.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_dec
  import timer_pkg::*;
(
  input  bcd_t digit,
  input  logic borrow_in,
  input  bcd_t wrap,
  output bcd_t next_digit,
  output logic borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = wrap;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_digit_loader.sv
// +--------------------------------------------------------------------------+
// | timer_digit_loader: keypad digit entry into MM:SS and 1 Hz countdown.     |
// | Option macro: TIMER_SEC_CLAMP_EN (clamp sec_tens to 5 on entry to RUN).  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module timer_digit_loader
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] dados,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  state_t state, state_nxt;
  bcd_t   mt_q, mo_q, st_q, so_q;
  bcd_t   mt_n, mo_n, st_n, so_n;
  bcd_t   mt_dec, mo_dec, st_dec, so_dec;
  logic   b_so, b_st, b_mo, b_mt;
  logic   loadn_d, running_q, done_q;
  logic   accept, nonzero, dec_zero;

  function automatic bcd_t run_sec_tens(input bcd_t v);
`ifdef TIMER_SEC_CLAMP_EN
    return (v > SEC_TENS_MAX) ? SEC_TENS_MAX : v;
`else
    return v;
`endif
  endfunction

  bcd_digit_dec u_dec_so (.digit(so_q), .borrow_in(1'b1), .wrap(BCD_MAX),
                          .next_digit(so_dec), .borrow_out(b_so));
  bcd_digit_dec u_dec_st (.digit(st_q), .borrow_in(b_so), .wrap(SEC_TENS_MAX),
                          .next_digit(st_dec), .borrow_out(b_st));
  bcd_digit_dec u_dec_mo (.digit(mo_q), .borrow_in(b_st), .wrap(BCD_MAX),
                          .next_digit(mo_dec), .borrow_out(b_mo));
  bcd_digit_dec u_dec_mt (.digit(mt_q), .borrow_in(b_mo), .wrap(BCD_MAX),
                          .next_digit(mt_dec), .borrow_out(b_mt));

  always_comb begin
    state_nxt = state;
    mt_n      = mt_q;
    mo_n      = mo_q;
    st_n      = st_q;
    so_n      = so_q;
    accept    = !loadn && loadn_d && (dados <= BCD_MAX);
    nonzero   = |{mt_q, mo_q, st_q, so_q};
    // A borrow out of the top digit would mean underflow; treat it as expiry.
    dec_zero  = ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000) || b_mt;

    if (clear) begin
      {mt_n, mo_n, st_n, so_n} = 16'h0000;
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            {mt_n, mo_n, st_n, so_n} = {mo_q, st_q, so_q, dados};
          end else if (start && nonzero) begin
            st_n      = run_sec_tens(st_q);
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pgt_1Hz) begin
            if (dec_zero) begin
              {mt_n, mo_n, st_n, so_n} = 16'h0000;
              state_nxt = ST_DONE;
            end else begin
              {mt_n, mo_n, st_n, so_n} = {mt_dec, mo_dec, st_dec, so_dec};
              if (pause) state_nxt = ST_PAUSE;
            end
          end else if (pause) begin
            state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            st_n      = run_sec_tens(st_q);
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (accept) begin
            {mt_n, mo_n, st_n, so_n} = {12'h000, dados};
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      mt_q      <= 4'd0;
      mo_q      <= 4'd0;
      st_q      <= 4'd0;
      so_q      <= 4'd0;
      loadn_d   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mt_q      <= mt_n;
      mo_q      <= mo_n;
      st_q      <= st_n;
      so_q      <= so_n;
      loadn_d   <= loadn;
      running_q <= (state_nxt == ST_RUN);
      done_q    <= (state_nxt == ST_DONE);
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

`default_nettype wire
